// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin serialisation onto one valid/ready consumer.
// Optional build macro EDGE_ARB_SYNC_EN adds a 2-flop input synchroniser per channel.
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     signal,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_id,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             drop_clr
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Number of set bits; N never exceeds 16 so five bits suffice.
    function automatic logic [4:0] popcount(input logic [N-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < N; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // First requesting channel after 'last', wrapping; the lowest offset wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = last;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[IDX_W'(idx)]) begin
                pick = ID_W'(idx);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    logic [N-1:0]     sig_s;
    logic [N-1:0]     prev_r;
    logic [N-1:0]     pending_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             out_valid_r;
    logic [ID_W-1:0]  out_id_r;
    logic [ID_W-1:0]  last_grant_r;
    state_t           state_r;

    logic [N-1:0]     edge_s;
    logic             handshake_s;
    logic [N-1:0]     clr_mask_s;
    logic [N-1:0]     drop_s;
    logic [N-1:0]     pending_nxt_s;
    logic [SUM_W-1:0] drop_sum_s;
    logic [CNT_W-1:0] drop_cnt_nxt_s;
    state_t           state_nxt_s;
    logic             out_valid_nxt_s;
    logic [ID_W-1:0]  out_id_nxt_s;
    logic [ID_W-1:0]  last_grant_nxt_s;

`ifdef EDGE_ARB_SYNC_EN
    logic [N-1:0] sync1_r;
    logic [N-1:0] sync2_r;

    // Two-stage synchroniser for inputs arriving from asynchronous pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N{1'b0}};
            sync2_r <= {N{1'b0}};
        end else begin
            sync1_r <= signal;
            sync2_r <= sync1_r;
        end
    end

    assign sig_s = sync2_r;
`else
    assign sig_s = signal;
`endif

    // Edge detect, pending latch update and drop accounting.
    always_comb begin
        edge_s         = sig_s & ~prev_r;
        handshake_s    = out_valid_r & out_ready;
        clr_mask_s     = {N{1'b0}};
        if (handshake_s) begin
            clr_mask_s = {{(N-1){1'b0}}, 1'b1} << out_id_r;
        end else begin
            clr_mask_s = {N{1'b0}};
        end
        // A fresh edge on the channel being retired survives as a new event.
        pending_nxt_s  = (pending_r & ~clr_mask_s) | edge_s;
        drop_s         = edge_s & pending_r & ~clr_mask_s;
        drop_sum_s     = SUM_W'(drop_cnt_r) + SUM_W'(popcount(drop_s));
        drop_cnt_nxt_s = drop_cnt_r;
        if (drop_clr) begin
            drop_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (drop_sum_s > SUM_W'(CNT_MAX)) begin
            drop_cnt_nxt_s = CNT_MAX;
        end else begin
            drop_cnt_nxt_s = CNT_W'(drop_sum_s);
        end
    end

    // Datapath registers: input history, pending flags, drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r     <= {N{1'b0}};
            pending_r  <= {N{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            prev_r     <= sig_s;
            pending_r  <= pending_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    // Scheduler next-state and registered offer outputs.
    always_comb begin
        state_nxt_s      = state_r;
        out_valid_nxt_s  = out_valid_r;
        out_id_nxt_s     = out_id_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != {N{1'b0}}) begin
                    out_id_nxt_s    = rr_pick(pending_r, last_grant_r);
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_OFFER;
                end else begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    last_grant_nxt_s = out_id_r;
                    out_valid_nxt_s  = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    out_valid_nxt_s  = 1'b1;
                    state_nxt_s      = ST_OFFER;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            out_valid_r  <= 1'b0;
            out_id_r     <= {ID_W{1'b0}};
            last_grant_r <= ID_W'(N - 1);
        end else begin
            state_r      <= state_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_id_r     <= out_id_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign pending   = pending_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: event-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_edge_event_arbiter;

    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     signal = '0;
    logic             out_ready = 1'b0;
    logic             drop_clr = 1'b0;
    logic             out_valid;
    logic [ID_W-1:0]  out_id;
    logic [N-1:0]     pending;
    logic [CNT_W-1:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit [N-1:0] m_prev  = '0;
    bit [N-1:0] m_pend  = '0;
    bit         m_valid = 1'b0;
    int         m_id    = 0;
    int         m_last  = N - 1;
    int         m_drop  = 0;

    int q[$];
    int cnt;

    edge_event_arbiter #(.N(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .signal(signal), .out_valid(out_valid),
        .out_id(out_id), .out_ready(out_ready), .pending(pending),
        .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_valid = 1'b0; m_id = 0; m_last = N - 1; m_drop = 0;
    endtask

    // Event-level rules: edges become events, busy channels lose them, grants rotate.
    task automatic model_step();
        bit [N-1:0] nxt;
        int         drops;
        bit         hs;
        bit         e;
        bit         clr;
        hs = m_valid && out_ready;
        drops = 0;
        for (int i = 0; i < N; i++) begin
            e   = signal[i] && !m_prev[i];
            clr = hs && (m_id == i);
            if (e && m_pend[i] && !clr) drops++;
            nxt[i] = e || (m_pend[i] && !clr);
        end
        if (drop_clr) m_drop = 0;
        else m_drop = (m_drop + drops > CMAX) ? CMAX : m_drop + drops;
        if (m_valid) begin
            if (out_ready) begin
                m_last  = m_id;
                m_valid = 1'b0;
            end
        end else if (m_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_pend[c]) begin
                    m_id    = c;
                    m_valid = 1'b1;
                    break;
                end
            end
        end
        m_pend = nxt;
        m_prev = signal;
    endtask

    // Advance the model on each edge and compare all outputs just after it.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check("cyc_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) check("cyc_id", 32'(out_id), 32'(m_id));
        check("cyc_pending", 32'(pending), 32'(m_pend));
        check("cyc_drop", 32'(drop_cnt), 32'(m_drop));
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic collect(input int cycles);
        q.delete();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) q.push_back(int'(out_id));
        end
    endtask

    task automatic pulse(input logic [N-1:0] v);
        signal = v;
        @(negedge clk);
        signal = '0;
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single event with consumer always ready; held input gives one event only.
        @(negedge clk);
        signal = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        check("single_pend", 32'(pending), 32'd1);
        check("single_nov", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_id", 32'(out_id), 32'd0);
        @(negedge clk);
        check("single_done", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("held_novalid", 32'(out_valid), 32'd0);
        check("held_nopend", 32'(pending), 32'd0);
        signal = '0;

        // Round robin from reset, then wrap from channel 3 back to 0.
        do_reset();
        signal = 4'b1111; out_ready = 1'b1;
        collect(10);
        check("rr_count", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", (i < q.size()) ? 32'(q[i]) : 32'hFFFF, 32'(i));
        signal = '0;
        @(negedge clk);
        signal = 4'b1001;
        collect(8);
        check("wrap_count", 32'(q.size()), 32'd2);
        check("wrap_first", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF, 32'd0);
        check("wrap_second", (q.size() > 1) ? 32'(q[1]) : 32'hFFFF, 32'd3);
        signal = '0;
        @(negedge clk);

        // Backpressure: repeated pulses on a busy channel are dropped.
        out_ready = 1'b0;
        pulse(4'b0100);
        pulse(4'b0100);
        pulse(4'b0100);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_id", 32'(out_id), 32'd2);
        check("bp_pend", 32'(pending), 32'b0100);
        check("bp_drop", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_clear", 32'(pending), 32'd0);
        check("bp_drop_kept", 32'(drop_cnt), 32'd2);

        // New edge coinciding with the handshake of the same channel.
        signal = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        check("sim_valid", 32'(out_valid), 32'd1);
        check("sim_id", 32'(out_id), 32'd1);
        signal = '0;
        @(negedge clk);
        signal = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("sim_pend_kept", 32'(pending), 32'b0010);
        check("sim_drop", 32'(drop_cnt), 32'd2);
        @(negedge clk);
        check("sim_reoffer", 32'(out_valid), 32'd1);
        check("sim_reoffer_id", 32'(out_id), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; signal = '0;
        check("sim_cleared", 32'(pending), 32'd0);

        // Saturation and clear priority.
        drop_clr = 1'b1;
        @(negedge clk);
        drop_clr = 1'b0;
        check("clr_zero", 32'(drop_cnt), 32'd0);
        pulse(4'b0001);
        for (int i = 0; i < 5; i++) pulse(4'b0001);
        check("sat_drop", 32'(drop_cnt), 32'd3);
        signal = 4'b0001; drop_clr = 1'b1;
        @(negedge clk);
        signal = '0; drop_clr = 1'b0;
        check("clr_prio", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        pulse(4'b1110);
        check("multi_none", 32'(drop_cnt), 32'd0);
        pulse(4'b0110);
        check("multi_two", 32'(drop_cnt), 32'd2);
        pulse(4'b1111);
        check("multi_sat", 32'(drop_cnt), 32'd3);

        // Asynchronous reset in the middle of an offer.
        signal = 4'b0001;
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pending", 32'(pending), 32'd0);
        check("arst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        collect(8);
        check("arst_events", 32'(q.size()), 32'd1);
        check("arst_id", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF, 32'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("arst_quiet", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event collector and round-robin scheduler.
- Detects rising edges on N level inputs (buttons or switches) and latches each edge as a pending event.
- Serializes the pending events, one at a time, to a single shared consumer (counter, display, or FSM) over a valid/ready handshake.
- Sits between the raw input pins and the shared datapath; lets several inputs share one event consumer without losing order fairness.

Parameters:
- N, 4, number of input channels (2..16).
- ID_W, 2, width of out_id; must satisfy 2**ID_W >= N.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- signal  input  N  level inputs, one per channel.
- out_valid  output  1  event offered to consumer.
- out_id  output  ID_W  channel index of the offered event.
- out_ready  input  1  consumer accepts the event this cycle.
- pending  output  N  per-channel latched-event flags.
- drop_cnt  output  CNT_W  count of edges lost because the channel was already pending.
- drop_clr  input  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - prev, pending, out_valid, out_id, drop_cnt are all cleared to 0.
  - last_grant is set to N-1; FSM goes to IDLE.
  - Outputs drop immediately, without waiting for a clock edge.
  - Reset mid-handshake discards the offered event and all pending events.
- Edge detect, per channel i:
  - edge[i] = signal[i] & ~prev[i]; prev[i] <= signal[i] every cycle.
  - prev resets to 0, so an input already high at reset release yields exactly one event.
  - A held-high input yields only one event. A 1-cycle high pulse yields one event.
- Pending latch:
  - On edge[i], pending[i] is set at that posedge.
  - pending[i] clears on a handshake (out_valid & out_ready & out_id==i).
  - Edge and handshake on the same channel in the same cycle: pending[i] stays 1, because the new event is kept.
  - Edge while pending[i]=1 and no clearing handshake: the event is dropped and drop_cnt increments.
  - drop_cnt saturates at 2**CNT_W-1.
  - Multiple channels dropping in the same cycle add the number of dropped channels, still saturating.
  - drop_clr has priority over increments in the same cycle; the result is 0.
- FSM, state IDLE:
  - If pending is non-zero, select the first set bit searching (last_grant+1) mod N upward with wrap.
  - Register out_id to that channel, set out_valid=1, go to OFFER.
  - A selection considers only pending bits registered before this edge.
- FSM, state OFFER:
  - out_valid=1; out_id holds stable until the handshake.
  - On out_ready: clear pending[out_id] (subject to the same-cycle edge rule), last_grant <= out_id, out_valid <= 0, go to IDLE.
  - Without out_ready: stay in OFFER; no re-arbitration, no pre-emption.
- Latency and throughput:
  - Take E0 as the first posedge sampling signal[i]=1 with the channel winning arbitration.
  - pending[i]=1 after E0; out_valid=1 after E0+1.
  - Maximum throughput is one event per 2 cycles (the IDLE bubble is mandatory).
- Fairness: after channel i is granted, every other pending channel is served before i is served again.

Optional Feature:
- Macro: EDGE_ARB_SYNC_EN.
- Defined:
  - Each signal bit passes through a 2-flop synchronizer before edge detection.
  - Synchronizer flops reset to 0; latency grows by 2 cycles (out_valid after E0+3).
  - Required when inputs come straight from asynchronous pins.
- Undefined:
  - signal is used directly and is required to be synchronous to clk.
  - Latency is as stated in Behaviour.

Test Plan:
- Single event, out_ready held 1: rst_n released, signal=0001 rises at cycle 5 and stays high.
  - out_valid=1, out_id=0 at cycle 6 for one cycle.
  - pending=0 after the handshake; no further events while held.
- Round robin: signal 0000->1111 in one cycle, out_ready=1.
  - Grants are 0,1,2,3 on alternate cycles.
  - Then re-raise channels 0 and 3: grants are 0 then 3 (last_grant=3 wraps to 0 first).
- Backpressure and drops: out_ready=0; channel 2 pulses high for 1 cycle, three times.
  - out_valid=1, out_id=2 held stable; pending[2]=1; drop_cnt=2.
  - Assert out_ready one cycle: pending[2]=0; drop_cnt stays 2.
- Simultaneous edge and grant: channel 1 offered in OFFER; a new edge on signal[1] coincides with out_ready=1.
  - pending[1] stays 1; channel 1 is offered again 2 cycles later; drop_cnt unchanged.
- Saturation and clear (CNT_W=2): force 5 drops, and drop_cnt=3. Pulse drop_clr concurrently with a further drop, and drop_cnt=0.
- Async reset mid-offer: rst_n=0 between clock edges while out_valid=1.
  - out_valid, pending, drop_cnt are 0 immediately.
  - After release with signal[0] still high, exactly one event for channel 0.
